// File: rtl/router_pkg.sv
// Shared router definitions: byte width, header address field and FSM strobe bundle.
package router_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'b11;

    typedef logic [DATA_W-1:0] byte_t;

    // One-hot control-FSM strobes that the parity accumulator acts on.
    typedef struct packed {
        logic detect_add;
        logic lfd;
        logic ld;
        logic laf;
        logic rst_int;
    } strb_t;

    function automatic logic [ADDR_W-1:0] hdr_addr(input byte_t h);
        return h[ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity of written bytes, captured packet parity byte, and the err compare.
module router_parity_acc
    import router_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  strb_t strb,
    input  logic  packet_valid,
    input  logic  fifo_full,
    input  logic  fpay,
    input  byte_t datain,
    input  byte_t hdr,
    input  byte_t fbyte,
    input  logic  parity_done,
    output logic  err
);

    byte_t ipar;
    byte_t ppar;

    // Only payload bytes are folded in; the parity byte itself (packet_valid low,
    // or fpay low when it was parked in fbyte) stays out of ipar.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipar <= '0;
        end else if (strb.detect_add) begin
            ipar <= '0;
        end else if (strb.lfd) begin
            ipar <= ipar ^ hdr;
        end else if (strb.ld && packet_valid && !fifo_full) begin
            ipar <= ipar ^ datain;
        end else if (strb.laf && fpay) begin
            ipar <= ipar ^ fbyte;
        end
    end

    // Parity byte is latched even when the FIFO is full; it is a compare operand, not a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ppar <= '0;
        end else if (strb.detect_add) begin
            ppar <= '0;
        end else if (strb.ld && !packet_valid) begin
            ppar <= datain;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (strb.lfd) begin
            err <= 1'b0;
        end else if (strb.rst_int && parity_done) begin
            err <= (ipar != ppar);
        end
    end

endmodule

// File: rtl/router_data_reg.sv
// Router datapath register: header hold, full-byte buffer, dout staging and packet status flags.
module router_data_reg
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              packet_valid,
    input  logic [DATA_W-1:0] datain,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err,
    output logic [DATA_W-1:0] dout
);

    byte_t hdr;
    byte_t fbyte;
    logic  fpay;
    strb_t strb;

    assign strb = '{detect_add: detect_add, lfd: lfd_state, ld: ld_state,
                    laf: laf_state, rst_int: rst_int_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr <= '0;
        end else if (detect_add && packet_valid) begin
            hdr <= datain;
        end
    end

    // fpay remembers whether the parked byte was payload or the parity byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            fbyte <= '0;
            fpay  <= 1'b0;
        end else if (lfd_state) begin
            dout <= hdr;
        end else if (ld_state && !fifo_full) begin
            dout <= datain;
        end else if (ld_state && fifo_full) begin
            fbyte <= datain;
            fpay  <= packet_valid;
        end else if (laf_state) begin
            dout <= fbyte;
        end else if (full_state) begin
            dout <= dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state && !packet_valid) begin
            low_packet_valid <= 1'b1;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end
    end

    // When the parity byte met a full FIFO, the packet closes once it drains in laf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (ld_state && !fifo_full && !packet_valid) begin
            parity_done <= 1'b1;
        end else if (laf_state && low_packet_valid && !parity_done) begin
            parity_done <= 1'b1;
        end
    end

    router_parity_acc u_par (
        .clk          (clk),
        .reset        (reset),
        .strb         (strb),
        .packet_valid (packet_valid),
        .fifo_full    (fifo_full),
        .fpay         (fpay),
        .datain       (datain),
        .hdr          (hdr),
        .fbyte        (fbyte),
        .parity_done  (parity_done),
        .err          (err)
    );

endmodule

// File: tb/tb_router_data_reg.sv
// Directed vector bench for router_data_reg: table of per-cycle strobes with expected outputs.
module tb_router_data_reg;
    import router_pkg::*;

    typedef enum logic [2:0] {S_NONE, S_DA, S_LFD, S_LD, S_LAF, S_FULL, S_RST} st_e;

    typedef struct {
        st_e   st;
        logic  pv;
        logic  full;
        byte_t din;
        byte_t edout;
        logic  epd;
        logic  elpv;
        logic  eerr;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  packet_valid = 1'b0;
    byte_t datain = '0;
    logic  fifo_full = 1'b0;
    logic  detect_add = 1'b0, lfd_state = 1'b0, ld_state = 1'b0;
    logic  laf_state = 1'b0, full_state = 1'b0, rst_int_reg = 1'b0;
    logic  parity_done, low_packet_valid, err;
    byte_t dout;

    int n_vec = 0;
    int n_bad = 0;

    router_data_reg dut (
        .clk              (clk),
        .reset            (reset),
        .packet_valid     (packet_valid),
        .datain           (datain),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err),
        .dout             (dout)
    );

    always #5 clk = ~clk;

    task automatic drive(input st_e st, input logic pv, input logic full, input byte_t din);
        detect_add   = (st == S_DA);
        lfd_state    = (st == S_LFD);
        ld_state     = (st == S_LD);
        laf_state    = (st == S_LAF);
        full_state   = (st == S_FULL);
        rst_int_reg  = (st == S_RST);
        packet_valid = pv;
        fifo_full    = full;
        datain       = din;
    endtask

    task automatic chk(input string name, input byte_t edout, input logic epd,
                       input logic elpv, input logic eerr);
        n_vec++;
        if (dout !== edout || parity_done !== epd || low_packet_valid !== elpv || err !== eerr) begin
            n_bad++;
            $display("FAIL %s: got dout=%02h pd=%b lpv=%b err=%b, want dout=%02h pd=%b lpv=%b err=%b",
                     name, dout, parity_done, low_packet_valid, err, edout, epd, elpv, eerr);
        end
    endtask

    task automatic step(input string name, input st_e st, input logic pv, input logic full,
                        input byte_t din, input byte_t edout, input logic epd,
                        input logic elpv, input logic eerr);
        drive(st, pv, full, din);
        @(posedge clk);
        #1;
        chk(name, edout, epd, elpv, eerr);
    endtask

    task automatic async_reset(input string name);
        drive(S_NONE, 1'b0, 1'b0, 8'h00);
        #2 reset = 1'b1;
        #1 chk(name, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        tbl = '{
            // clean packet 05/3C/39
            '{S_DA,   1, 0, 8'h05, 8'h00, 0, 0, 0},
            '{S_LFD,  1, 0, 8'h00, 8'h05, 0, 0, 0},
            '{S_LD,   1, 0, 8'h3C, 8'h3C, 0, 0, 0},
            '{S_LD,   0, 0, 8'h39, 8'h39, 1, 1, 0},
            '{S_RST,  0, 0, 8'h00, 8'h39, 1, 0, 0},
            // bad parity 38: err holds through decode, clears on lfd
            '{S_DA,   1, 0, 8'h05, 8'h39, 0, 0, 0},
            '{S_LFD,  1, 0, 8'h00, 8'h05, 0, 0, 0},
            '{S_LD,   1, 0, 8'h3C, 8'h3C, 0, 0, 0},
            '{S_LD,   0, 0, 8'h38, 8'h38, 1, 1, 0},
            '{S_RST,  0, 0, 8'h00, 8'h38, 1, 0, 1},
            '{S_DA,   1, 0, 8'h0A, 8'h38, 0, 0, 1},
            '{S_LFD,  1, 0, 8'h00, 8'h0A, 0, 0, 0},
            // FIFO full on payload 22, drained in laf and folded into parity
            '{S_LD,   1, 0, 8'h11, 8'h11, 0, 0, 0},
            '{S_LD,   1, 1, 8'h22, 8'h11, 0, 0, 0},
            '{S_FULL, 1, 1, 8'hAA, 8'h11, 0, 0, 0},
            '{S_LAF,  1, 0, 8'h00, 8'h22, 0, 0, 0},
            '{S_LD,   0, 0, 8'h39, 8'h39, 1, 1, 0},
            '{S_RST,  0, 0, 8'h00, 8'h39, 1, 0, 0},
            // FIFO full on parity byte 7E: lpv first, parity_done in laf, 7E not in ipar
            '{S_DA,   1, 0, 8'h03, 8'h39, 0, 0, 0},
            '{S_LFD,  1, 0, 8'h00, 8'h03, 0, 0, 0},
            '{S_LD,   1, 0, 8'h7D, 8'h7D, 0, 0, 0},
            '{S_LD,   0, 1, 8'h7E, 8'h7D, 0, 1, 0},
            '{S_FULL, 0, 1, 8'h00, 8'h7D, 0, 1, 0},
            '{S_LAF,  0, 0, 8'h00, 8'h7E, 1, 1, 0},
            '{S_RST,  0, 0, 8'h00, 8'h7E, 1, 0, 0},
            // header-only packet with wrong parity, then idle hold
            '{S_DA,   1, 0, 8'h55, 8'h7E, 0, 0, 0},
            '{S_LFD,  1, 0, 8'h00, 8'h55, 0, 0, 0},
            '{S_LD,   0, 0, 8'h12, 8'h12, 1, 1, 0},
            '{S_RST,  0, 0, 8'h00, 8'h12, 1, 0, 1},
            '{S_NONE, 0, 0, 8'hFF, 8'h12, 1, 0, 1}
        };

        drive(S_NONE, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 chk("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i].st, tbl[i].pv, tbl[i].full, tbl[i].din,
                 tbl[i].edout, tbl[i].epd, tbl[i].elpv, tbl[i].eerr);

        // async reset while err/parity_done/dout are all set
        async_reset("rst_with_err");

        // async reset mid-payload with lpv and parity_done set
        step("mid_da",  S_DA,  1, 0, 8'h44, 8'h00, 0, 0, 0);
        step("mid_lfd", S_LFD, 1, 0, 8'h00, 8'h44, 0, 0, 0);
        step("mid_ld",  S_LD,  1, 0, 8'h66, 8'h66, 0, 0, 0);
        step("mid_par", S_LD,  0, 0, 8'h99, 8'h99, 1, 1, 0);
        async_reset("rst_mid_payload");

        // header register cleared by reset
        step("hdr_cleared", S_LFD, 1, 0, 8'h00, 8'h00, 0, 0, 0);

        // packet after reset: 01/FF/FE
        step("post_da",  S_DA,  1, 0, 8'h01, 8'h00, 0, 0, 0);
        step("post_lfd", S_LFD, 1, 0, 8'h00, 8'h01, 0, 0, 0);
        step("post_ld",  S_LD,  1, 0, 8'hFF, 8'hFF, 0, 0, 0);
        step("post_par", S_LD,  0, 0, 8'hFE, 8'hFE, 1, 1, 0);
        step("post_rst", S_RST, 0, 0, 8'h00, 8'hFE, 1, 0, 0);

        // back-to-back: second packet parity independent of the first
        step("b2b_da",  S_DA,  1, 0, 8'h02, 8'hFE, 0, 0, 0);
        step("b2b_lfd", S_LFD, 1, 0, 8'h00, 8'h02, 0, 0, 0);
        step("b2b_ld",  S_LD,  1, 0, 8'h80, 8'h80, 0, 0, 0);
        step("b2b_par", S_LD,  0, 0, 8'h82, 8'h82, 1, 1, 0);
        step("b2b_rst", S_RST, 0, 0, 8'h00, 8'h82, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
